// File: rtl/xor_decrypt_receiver.sv
// Serial XOR-decrypting receiver: shifts in a key and a flagged ciphertext frame,
// then XORs the frame with the replicated key and reports valid/error pulses.
module xor_decrypt_receiver #(
   parameter int MSG_SIZE = 64,
   parameter int KEY_SIZE = 8
) (
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic                      iEn,
   input  logic                      iSerial_in,
   input  logic                      iSerial_flag,
   input  logic                      iKey_in,
   input  logic                      iLoad_key,
   output logic [MSG_SIZE-1:0]       oPlaintext,
   output logic                      oValid,
   output logic                      oError,
   output logic                      oKey_ready,
   output logic [$clog2(MSG_SIZE):0] oBit_counter
);

   localparam int CNT_W  = $clog2(MSG_SIZE) + 1;
   localparam int KCNT_W = $clog2(KEY_SIZE) + 1;
   localparam int REPS   = MSG_SIZE / KEY_SIZE;

   localparam logic [CNT_W-1:0]  MSG_LAST = CNT_W'(MSG_SIZE - 1);
   localparam logic [KCNT_W-1:0] KEY_FULL = KCNT_W'(KEY_SIZE);

   typedef enum logic [1:0] {IDLE, RECV, DECRYPT, HOLD} state_t;

   state_t              state;
   logic [MSG_SIZE-1:0] frame_reg;
   logic [KEY_SIZE-1:0] key_reg;
   logic [KCNT_W-1:0]   key_count;
   logic                key_loading;

   // A fresh load burst (iLoad_key rising) restarts the count so a partial reload never looks complete
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         key_reg     <= '0;
         key_count   <= '0;
         key_loading <= 1'b0;
      end else if (iEn) begin
         key_loading <= iLoad_key;
         if (iLoad_key) begin
            key_reg <= (key_reg << 1) | KEY_SIZE'(iKey_in);
            if (!key_loading)
               key_count <= KCNT_W'(1);
            else if (key_count != KEY_FULL)
               key_count <= key_count + 1'b1;
         end
      end
   end

   assign oKey_ready = (key_count == KEY_FULL);

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state        <= IDLE;
         frame_reg    <= '0;
         oPlaintext   <= '0;
         oValid       <= 1'b0;
         oError       <= 1'b0;
         oBit_counter <= '0;
      end else begin
         oValid <= 1'b0;
         oError <= 1'b0;
         if (iEn) begin
            unique case (state)
               IDLE: begin
                  if (iSerial_flag) begin
                     frame_reg    <= {frame_reg[MSG_SIZE-2:0], iSerial_in};
                     oBit_counter <= CNT_W'(1);
                     state        <= RECV;
                  end
               end
               RECV: begin
                  if (iSerial_flag) begin
                     frame_reg    <= {frame_reg[MSG_SIZE-2:0], iSerial_in};
                     oBit_counter <= oBit_counter + 1'b1;
                     if (oBit_counter == MSG_LAST)
                        state <= DECRYPT;
                  end else begin
                     oError       <= 1'b1;
                     oBit_counter <= '0;
                     state        <= IDLE;
                  end
               end
               DECRYPT: begin
                  if (oKey_ready) begin
                     oPlaintext <= frame_reg ^ {REPS{key_reg}};
                     oValid     <= 1'b1;
                  end else begin
                     oError <= 1'b1;
                  end
                  oBit_counter <= '0;
                  state        <= iSerial_flag ? HOLD : IDLE;
               end
               // Excess bits of an overlong frame are swallowed here, never starting a new frame
               HOLD: begin
                  if (!iSerial_flag)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_xor_decrypt_receiver.sv
// Directed testbench for xor_decrypt_receiver: key load, normal/truncated/stalled/
// overlong frames, missing key and asynchronous reset mid-frame.
module tb_xor_decrypt_receiver;

   localparam int MSG_SIZE = 64;
   localparam int KEY_SIZE = 8;

   localparam logic [63:0] FRAME1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] EXP1   = 64'hA486E0C22C0E684A;
   localparam logic [63:0] FRAME2 = 64'hFEDCBA9876543210;
   localparam logic [63:0] EXP2   = 64'hC2E086A44A680E2C;

   logic                      iClk;
   logic                      iRst;
   logic                      iEn;
   logic                      iSerial_in;
   logic                      iSerial_flag;
   logic                      iKey_in;
   logic                      iLoad_key;
   logic [MSG_SIZE-1:0]       oPlaintext;
   logic                      oValid;
   logic                      oError;
   logic                      oKey_ready;
   logic [$clog2(MSG_SIZE):0] oBit_counter;

   int vectorCount  = 0;
   int missCount    = 0;
   int validPulses  = 0;
   int errorPulses  = 0;
   int overlapCount = 0;
   int v0;
   int e0;

   xor_decrypt_receiver #(.MSG_SIZE(MSG_SIZE), .KEY_SIZE(KEY_SIZE)) dut (
      .iClk         (iClk),
      .iRst         (iRst),
      .iEn          (iEn),
      .iSerial_in   (iSerial_in),
      .iSerial_flag (iSerial_flag),
      .iKey_in      (iKey_in),
      .iLoad_key    (iLoad_key),
      .oPlaintext   (oPlaintext),
      .oValid       (oValid),
      .oError       (oError),
      .oKey_ready   (oKey_ready),
      .oBit_counter (oBit_counter)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // One clock edge; outputs are sampled 1 time unit after it and pulses tallied
   task automatic stepClock();
      @(posedge iClk);
      #1;
      if (oValid) validPulses++;
      if (oError) errorPulses++;
      if (oValid && oError) overlapCount++;
   endtask

   task automatic loadKey(input logic [KEY_SIZE-1:0] key);
      for (int i = KEY_SIZE - 1; i >= 0; i--) begin
         iLoad_key = 1'b1;
         iKey_in   = key[i];
         stepClock();
      end
      iLoad_key = 1'b0;
      iKey_in   = 1'b0;
   endtask

   // Sends nbits MSB first with the flag high; optional iEn stall after bit stallAt
   task automatic applyStimulus(input logic [63:0] frame, input int nbits, input int stallAt, input int stallLen);
      for (int i = 0; i < nbits; i++) begin
         iSerial_flag = 1'b1;
         iSerial_in   = (i < 64) ? frame[63-i] : 1'b1;
         stepClock();
         if (stallAt != 0 && i + 1 == stallAt) begin
            iEn = 1'b0;
            for (int s = 0; s < stallLen; s++) begin
               iSerial_in = s[0];
               stepClock();
               checkOutput("stall oValid", 64'(oValid), 64'd0);
               checkOutput("stall counter", 64'(oBit_counter), 64'(stallAt));
            end
            iEn = 1'b1;
         end
      end
      iSerial_flag = 1'b0;
      iSerial_in   = 1'b0;
   endtask

   initial begin
      iRst = 1'b1; iEn = 1'b1; iSerial_in = 1'b0; iSerial_flag = 1'b0;
      iKey_in = 1'b0; iLoad_key = 1'b0;
      #3;
      checkOutput("reset plaintext", oPlaintext, 64'd0);
      checkOutput("reset valid", 64'(oValid), 64'd0);
      checkOutput("reset error", 64'(oError), 64'd0);
      checkOutput("reset key_ready", 64'(oKey_ready), 64'd0);
      checkOutput("reset counter", 64'(oBit_counter), 64'd0);
      stepClock();
      iRst = 1'b0;
      stepClock();

      $display("[TB] missing key");
      applyStimulus(FRAME1, 64, 0, 0);
      stepClock();
      checkOutput("nokey error", 64'(oError), 64'd1);
      checkOutput("nokey valid", 64'(oValid), 64'd0);
      checkOutput("nokey plaintext", oPlaintext, 64'd0);
      checkOutput("nokey key_ready", 64'(oKey_ready), 64'd0);
      stepClock();

      $display("[TB] normal frame");
      loadKey(8'hA5);
      checkOutput("key_ready after load", 64'(oKey_ready), 64'd1);
      v0 = validPulses;
      applyStimulus(FRAME1, 64, 0, 0);
      checkOutput("last bit counter", 64'(oBit_counter), 64'd64);
      checkOutput("valid 1 edge after last", 64'(oValid), 64'd0);
      stepClock();
      checkOutput("normal valid", 64'(oValid), 64'd1);
      checkOutput("normal plaintext", oPlaintext, EXP1);
      checkOutput("normal counter cleared", 64'(oBit_counter), 64'd0);
      stepClock();
      checkOutput("valid pulse width", 64'(oValid), 64'd0);
      checkOutput("normal valid count", 64'(validPulses - v0), 64'd1);

      $display("[TB] truncated frame");
      v0 = validPulses;
      applyStimulus(FRAME2, 40, 0, 0);
      checkOutput("trunc counter", 64'(oBit_counter), 64'd40);
      stepClock();
      checkOutput("trunc error", 64'(oError), 64'd1);
      checkOutput("trunc plaintext", oPlaintext, EXP1);
      checkOutput("trunc counter cleared", 64'(oBit_counter), 64'd0);
      stepClock();
      checkOutput("trunc error width", 64'(oError), 64'd0);
      checkOutput("trunc no valid", 64'(validPulses - v0), 64'd0);

      $display("[TB] stalled frame");
      applyStimulus(FRAME1, 64, 20, 10);
      stepClock();
      checkOutput("stall result valid", 64'(oValid), 64'd1);
      checkOutput("stall plaintext", oPlaintext, EXP1);
      stepClock();

      $display("[TB] key reload");
      iLoad_key = 1'b1; iKey_in = 1'b1;
      stepClock();
      checkOutput("reload restarts key_ready", 64'(oKey_ready), 64'd0);
      iLoad_key = 1'b0; iKey_in = 1'b0;
      stepClock();
      checkOutput("partial key not ready", 64'(oKey_ready), 64'd0);
      loadKey(8'h3C);
      checkOutput("new key ready", 64'(oKey_ready), 64'd1);
      applyStimulus(FRAME2, 64, 0, 0);
      stepClock();
      checkOutput("key2 valid", 64'(oValid), 64'd1);
      checkOutput("key2 plaintext", oPlaintext, EXP2);
      stepClock();

      $display("[TB] overlong flag");
      loadKey(8'hA5);
      v0 = validPulses;
      e0 = errorPulses;
      applyStimulus(FRAME1, 70, 0, 0);
      checkOutput("hold counter", 64'(oBit_counter), 64'd0);
      stepClock();
      stepClock();
      stepClock();
      checkOutput("overlong counter idle", 64'(oBit_counter), 64'd0);
      checkOutput("overlong valid count", 64'(validPulses - v0), 64'd1);
      checkOutput("overlong error count", 64'(errorPulses - e0), 64'd0);
      checkOutput("overlong plaintext", oPlaintext, EXP1);

      $display("[TB] reset mid-frame");
      applyStimulus(FRAME2, 30, 0, 0);
      iRst = 1'b1;
      #2;
      checkOutput("rst plaintext", oPlaintext, 64'd0);
      checkOutput("rst counter", 64'(oBit_counter), 64'd0);
      checkOutput("rst key_ready", 64'(oKey_ready), 64'd0);
      checkOutput("rst valid", 64'(oValid), 64'd0);
      checkOutput("rst error", 64'(oError), 64'd0);
      stepClock();
      iRst = 1'b0;
      stepClock();
      checkOutput("post-rst counter", 64'(oBit_counter), 64'd0);
      loadKey(8'hA5);
      applyStimulus(FRAME1, 64, 0, 0);
      stepClock();
      checkOutput("post-rst valid", 64'(oValid), 64'd1);
      checkOutput("post-rst plaintext", oPlaintext, EXP1);
      stepClock();

      checkOutput("valid/error overlap", 64'(overlapCount), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/xor_decrypt_receiver.md
XOR_DECRYPT_RECEIVER -- requirements
Module: xor_decrypt_receiver

Interface
REQ-001 SHALL have parameter MSG_SIZE, default 64: ciphertext/plaintext frame width in bits.
REQ-002 SHALL have parameter KEY_SIZE, default 8: XOR key width in bits; MSG_SIZE SHALL be an integer multiple of KEY_SIZE.
REQ-003 SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port iRst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port iEn, input, 1 bit: clock enable.
REQ-006 SHALL have port iSerial_in, input, 1 bit: ciphertext serial bit from the transmitter's serial output.
REQ-007 SHALL have port iSerial_flag, input, 1 bit: frame-valid flag from the transmitter's serial flag output.
REQ-008 SHALL have port iKey_in, input, 1 bit: serial key bit.
REQ-009 SHALL have port iLoad_key, input, 1 bit: key shift enable.
REQ-010 SHALL have port oPlaintext, output, MSG_SIZE bits: last decrypted frame.
REQ-011 SHALL have port oValid, output, 1 bit: one-cycle pulse when oPlaintext is updated.
REQ-012 SHALL have port oError, output, 1 bit: one-cycle pulse on a truncated frame or a missing key.
REQ-013 SHALL have port oKey_ready, output, 1 bit: high when a full key is held.
REQ-014 SHALL have port oBit_counter, output, $clog2(MSG_SIZE)+1 bits: count of frame bits captured so far.

Function
REQ-015 SHALL sample inputs only on rising edges with iEn=1; with iEn=0, all state SHALL hold and oValid/oError SHALL be 0.
REQ-016 SHALL shift serial data MSB first: key bits shift into key[0] with a left shift; frame bits do the same into a MSG_SIZE shift register.
REQ-017 Key load: each enabled cycle with iLoad_key=1 SHALL shift in iKey_in and increment the key count, which saturates at KEY_SIZE.
REQ-018 The first enabled cycle with iLoad_key=1 after iLoad_key=0 SHALL restart the key count at 1 and clear oKey_ready; oKey_ready=1 iff key count==KEY_SIZE.
REQ-019 Key loading SHALL be independent of frame reception; both may occur in the same cycle.
REQ-020 The FSM SHALL have states IDLE, RECV, DECRYPT and HOLD.
REQ-021 IDLE: on an enabled edge with iSerial_flag=1, SHALL capture the bit, set oBit_counter=1 and go to RECV; otherwise SHALL stay in IDLE.
REQ-022 RECV, iSerial_flag=1: SHALL capture the bit and increment oBit_counter; on reaching MSG_SIZE it SHALL go to DECRYPT.
REQ-023 RECV, iSerial_flag=0 before MSG_SIZE bits: SHALL pulse oError for 1 cycle, leave oPlaintext unchanged, clear oBit_counter and go to IDLE.
REQ-024 DECRYPT (one enabled cycle), oKey_ready=1: SHALL load oPlaintext = frame XOR the key replicated MSG_SIZE/KEY_SIZE times and pulse oValid.
REQ-025 DECRYPT, oKey_ready=0: SHALL pulse oError, leave oPlaintext unchanged and not pulse oValid.
REQ-026 Latency: oValid SHALL be high in the cycle after the enabled edge that follows the edge capturing bit MSG_SIZE, i.e. 2 enabled edges after the last bit.
REQ-027 DECRYPT SHALL use the key register value present at that edge.
REQ-028 On leaving DECRYPT, SHALL clear oBit_counter and go to HOLD if iSerial_flag=1, else to IDLE.
REQ-029 HOLD SHALL ignore iSerial_in until iSerial_flag=0, then go to IDLE; excess bits SHALL never start a new frame.
REQ-030 Back-to-back frames SHALL require at least one enabled cycle with iSerial_flag=0 between them.
REQ-031 oValid and oError SHALL never be high in the same cycle.

Reset
REQ-032 iRst=1 SHALL immediately force: state IDLE, oPlaintext=0, oValid=0, oError=0, oKey_ready=0, oBit_counter=0, key register and count 0, frame shift register 0.
REQ-033 Reset mid-frame or mid-key-load SHALL discard partial data; the block SHALL need no further initialisation after iRst falls.

Verification
REQ-034 Normal frame: load key 0xA5, then 64-bit frame 0x0123456789ABCDEF with flag high for 64 cycles -> oPlaintext=0xA486E0C22C0E684A, oValid for exactly 1 cycle, 2 edges after the last bit.
REQ-035 Truncated frame: flag drops after 40 bits -> oError for 1 cycle, no oValid, oPlaintext keeps its prior value, oBit_counter=0.
REQ-036 Missing key: after reset, send the full frame 0x0123456789ABCDEF -> oError pulse, oPlaintext=0, oKey_ready=0.
REQ-037 Stall: same frame as REQ-034 with iEn=0 for 10 cycles after bit 20 -> identical 0xA486E0C22C0E684A; oValid=0 during the stall.
REQ-038 Overlong flag and reset: hold the flag for 70 bits -> one oValid, the extra 6 bits ignored; then assert iRst after bit 30 of the next frame -> all outputs 0 and IDLE, and the next full frame decodes correctly once the key is reloaded.
